jlc3_run_ctrl: RTL and testbench

//   Parametrised run-control sequencer driving the en_i_w of NUM_CORES jlc3 cores from a

---
 rtl/jlc3_run_ctrl_if.sv | 28 ++
 rtl/jlc3_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_jlc3_run_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jlc3_run_ctrl_if.sv
// Command port bundle for the jlc3 run-control sequencer.
// master issues HALT/RUN/STEP/MASK commands, slave returns ready.
interface jlc3_run_ctrl_if #(
   parameter int NUM_CORES  = 1,
   parameter int STEP_CNT_W = 16
);
   logic                  cmd_valid_i_w;
   logic                  cmd_ready_o_w;
   logic [1:0]            cmd_op_i_w;
   logic [STEP_CNT_W-1:0] cmd_cnt_i_w;
   logic [NUM_CORES-1:0]  cmd_mask_i_w;

   modport master (
      output cmd_valid_i_w,
      output cmd_op_i_w,
      output cmd_cnt_i_w,
      output cmd_mask_i_w,
      input  cmd_ready_o_w
   );

   modport slave (
      input  cmd_valid_i_w,
      input  cmd_op_i_w,
      input  cmd_cnt_i_w,
      input  cmd_mask_i_w,
      output cmd_ready_o_w
   );
endinterface

// File: rtl/jlc3_run_ctrl.sv
// Run-control sequencer: halt / free-run / N-cycle step / mask for jlc3 cores.
// Optional enabled-cycle counter guarded by JLC3_RUN_CYC_CNT_EN.
module jlc3_run_ctrl #(
   parameter int NUM_CORES  = 1,
   parameter int STEP_CNT_W = 16,
   parameter int RST_HOLD   = 4
) (
   input  logic                 clk_i_w,
   input  logic                 rst_i_w,
   jlc3_run_ctrl_if.slave       cmd_if,
   input  logic [NUM_CORES-1:0] halt_req_i_w,
   output logic [NUM_CORES-1:0] en_o_w,
   output logic                 busy_o_w,
   output logic                 done_o_w,
   output logic                 err_o_w,
   output logic [31:0]          run_cyc_o_w
);
   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   localparam logic [1:0] OP_HALT = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_MASK = 2'b11;

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_IDLE = 2'd1,
      S_RUN  = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [HOLD_W-1:0]     r_hold;
   logic [HOLD_W-1:0]     w_hold_nxt;
   logic [STEP_CNT_W-1:0] r_step;
   logic [STEP_CNT_W-1:0] w_step_nxt;
   logic [NUM_CORES-1:0]  r_mask;
   logic [NUM_CORES-1:0]  w_mask_nxt;
   logic [NUM_CORES-1:0]  r_halted;
   logic [NUM_CORES-1:0]  w_halted_nxt;
   logic [NUM_CORES-1:0]  r_en;
   logic [NUM_CORES-1:0]  w_en_nxt;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  r_err;
   logic                  w_err_nxt;

   logic                  w_ready;
   logic                  w_acc;
   logic                  w_halt_cmd;
   logic                  w_last;
   logic [NUM_CORES-1:0]  w_eff;
   logic [NUM_CORES-1:0]  w_halted_upd;
   logic [NUM_CORES-1:0]  w_eff_run;

   assign w_ready      = (r_state != S_HOLD);
   assign w_acc        = cmd_if.cmd_valid_i_w & w_ready;
   assign w_halt_cmd   = w_acc & (cmd_if.cmd_op_i_w == OP_HALT);
   assign w_last       = (r_step == STEP_CNT_W'(1));
   assign w_eff        = r_mask & ~r_halted;
   // halt requests only count for cores that are actually enabled
   assign w_halted_upd = r_halted | (halt_req_i_w & r_en);
   assign w_eff_run    = r_mask & ~w_halted_upd;

   always_ff @(posedge clk_i_w or negedge rst_i_w) begin
      if (!rst_i_w) r_state <= S_HOLD;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_HOLD: begin
            if (r_hold == '0) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (w_acc && w_eff != '0) begin
               if (cmd_if.cmd_op_i_w == OP_RUN)
                  w_state_nxt = S_RUN;
               else if (cmd_if.cmd_op_i_w == OP_STEP &&
                        cmd_if.cmd_cnt_i_w != '0)
                  w_state_nxt = S_STEP;
            end
         end
         S_RUN: begin
            if (w_halt_cmd || w_eff_run == '0)
               w_state_nxt = S_IDLE;
         end
         S_STEP: begin
            if (w_halt_cmd || w_eff_run == '0 || w_last)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_HOLD;
      endcase
   end

   always_comb begin
      w_hold_nxt   = r_hold;
      w_step_nxt   = r_step;
      w_mask_nxt   = r_mask;
      w_halted_nxt = r_halted;
      w_en_nxt     = '0;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      unique case (r_state)
         S_HOLD: begin
            if (r_hold != '0) w_hold_nxt = r_hold - HOLD_W'(1);
         end
         S_IDLE: begin
            if (w_acc) begin
               unique case (cmd_if.cmd_op_i_w)
                  OP_MASK: begin
                     w_mask_nxt   = cmd_if.cmd_mask_i_w;
                     w_halted_nxt = '0;
                  end
                  OP_RUN: begin
                     if (w_eff == '0) w_done_nxt = 1'b1;
                     else             w_en_nxt   = w_eff;
                  end
                  OP_STEP: begin
                     if (w_eff == '0 || cmd_if.cmd_cnt_i_w == '0) begin
                        w_done_nxt = 1'b1;
                     end else begin
                        w_en_nxt   = w_eff;
                        w_step_nxt = cmd_if.cmd_cnt_i_w;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_RUN, S_STEP: begin
            w_halted_nxt = w_halted_upd;
            w_step_nxt   = (r_state == S_STEP) ? r_step - STEP_CNT_W'(1) : r_step;
            if (w_halt_cmd) begin
               w_step_nxt = '0;
            end else begin
               w_err_nxt = w_acc;
               if (w_eff_run == '0 || (r_state == S_STEP && w_last)) begin
                  w_done_nxt = 1'b1;
                  w_step_nxt = '0;
               end else begin
                  w_en_nxt = w_eff_run;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i_w or negedge rst_i_w) begin
      if (!rst_i_w) begin
         r_hold   <= HOLD_W'(RST_HOLD - 1);
         r_step   <= '0;
         r_mask   <= '1;
         r_halted <= '0;
         r_en     <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_hold   <= w_hold_nxt;
         r_step   <= w_step_nxt;
         r_mask   <= w_mask_nxt;
         r_halted <= w_halted_nxt;
         r_en     <= w_en_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

`ifdef JLC3_RUN_CYC_CNT_EN
   logic [31:0] r_cyc;
   logic        w_cyc_clr;

   assign w_cyc_clr = (r_state == S_IDLE) & w_acc &
                      (cmd_if.cmd_op_i_w == OP_MASK);

   always_ff @(posedge clk_i_w or negedge rst_i_w) begin
      if (!rst_i_w)      r_cyc <= '0;
      else if (w_cyc_clr) r_cyc <= '0;
      else if (|r_en)    r_cyc <= r_cyc + 32'd1;
   end

   assign run_cyc_o_w = r_cyc;
`else
   assign run_cyc_o_w = '0;
`endif

   assign cmd_if.cmd_ready_o_w = w_ready;
   assign en_o_w   = r_en;
   assign busy_o_w = (r_state == S_RUN) || (r_state == S_STEP);
   assign done_o_w = r_done;
   assign err_o_w  = r_err;
endmodule

// File: tb/tb_jlc3_run_ctrl.sv
// Directed bench for jlc3_run_ctrl with NUM_CORES=2, RST_HOLD=4.
// Works with or without JLC3_RUN_CYC_CNT_EN defined.
module tb_jlc3_run_ctrl;
   logic       clk;
   logic       rst_n;
   logic [1:0] halt_req;
   logic [1:0] en;
   logic       busy;
   logic       done;
   logic       err;
   logic [31:0] run_cyc;

   int nchk  = 0;
   int nfail = 0;

   jlc3_run_ctrl_if #(.NUM_CORES(2), .STEP_CNT_W(16)) u_if ();

   jlc3_run_ctrl #(
      .NUM_CORES (2),
      .STEP_CNT_W(16),
      .RST_HOLD  (4)
   ) u_dut (
      .clk_i_w     (clk),
      .rst_i_w     (rst_n),
      .cmd_if      (u_if.slave),
      .halt_req_i_w(halt_req),
      .en_o_w      (en),
      .busy_o_w    (busy),
      .done_o_w    (done),
      .err_o_w     (err),
      .run_cyc_o_w (run_cyc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] cnt,
                        input logic [1:0] mask);
      u_if.cmd_valid_i_w = 1'b1;
      u_if.cmd_op_i_w    = op;
      u_if.cmd_cnt_i_w   = cnt;
      u_if.cmd_mask_i_w  = mask;
      tick();
      u_if.cmd_valid_i_w = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      nchk++;
      if (en !== 2'b00 || u_if.cmd_ready_o_w !== 1'b0 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL reset_vals en=%b rdy=%b busy=%b want 00/0/0",
                  en, u_if.cmd_ready_o_w, busy);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (u_if.cmd_ready_o_w !== 1'b0) begin
            nfail++;
            $display("FAIL hold_ready cyc=%0d got=%b want 0", i, u_if.cmd_ready_o_w);
         end
         tick();
      end
      nchk++;
      if (u_if.cmd_ready_o_w !== 1'b1 || en !== 2'b00) begin
         nfail++;
         $display("FAIL hold_exit rdy=%b en=%b want 1/00", u_if.cmd_ready_o_w, en);
      end
   endtask

   task automatic test_step();
      logic [31:0] exp_cyc;
`ifdef JLC3_RUN_CYC_CNT_EN
      exp_cyc = 32'd3;
`else
      exp_cyc = 32'd0;
`endif
      issue(2'b10, 16'd3, 2'b00);
      for (int i = 0; i < 3; i++) begin
         nchk++;
         if (en !== 2'b11 || done !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL step3_en i=%0d en=%b done=%b busy=%b want 11/0/1",
                     i, en, done, busy);
         end
         tick();
      end
      nchk++;
      if (en !== 2'b00 || done !== 1'b1 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL step3_done en=%b done=%b busy=%b want 00/1/0", en, done, busy);
      end
      nchk++;
      if (run_cyc !== exp_cyc) begin
         nfail++;
         $display("FAIL step3_cyc got=%0d want %0d", run_cyc, exp_cyc);
      end
      tick();
      nchk++;
      if (done !== 1'b0) begin
         nfail++;
         $display("FAIL step3_pulse done=%b want 0", done);
      end
   endtask

   task automatic test_run_halt_req();
      issue(2'b01, 16'd0, 2'b00);
      nchk++;
      if (en !== 2'b11 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL run_start en=%b busy=%b want 11/1", en, busy);
      end
      repeat (4) tick();
      halt_req = 2'b01;
      tick();
      halt_req = 2'b00;
      nchk++;
      if (en !== 2'b10 || busy !== 1'b1 || done !== 1'b0) begin
         nfail++;
         $display("FAIL hreq0 en=%b busy=%b done=%b want 10/1/0", en, busy, done);
      end
      repeat (3) tick();
      halt_req = 2'b10;
      tick();
      halt_req = 2'b00;
      nchk++;
      if (en !== 2'b00 || busy !== 1'b0 || done !== 1'b1) begin
         nfail++;
         $display("FAIL hreq1 en=%b busy=%b done=%b want 00/0/1", en, busy, done);
      end
      tick();
      nchk++;
      if (done !== 1'b0) begin
         nfail++;
         $display("FAIL hreq_pulse done=%b want 0", done);
      end
      issue(2'b01, 16'd0, 2'b00);
      nchk++;
      if (en !== 2'b00 || done !== 1'b1 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL run_parked en=%b done=%b busy=%b want 00/1/0", en, done, busy);
      end
      tick();
      nchk++;
      if (en !== 2'b00 || done !== 1'b0) begin
         nfail++;
         $display("FAIL run_parked2 en=%b done=%b want 00/0", en, done);
      end
   endtask

   task automatic test_cmd_in_run();
      issue(2'b11, 16'd0, 2'b11);
      nchk++;
      if (run_cyc !== 32'd0) begin
         nfail++;
         $display("FAIL mask_clr_cyc got=%0d want 0", run_cyc);
      end
      issue(2'b01, 16'd0, 2'b00);
      issue(2'b10, 16'd5, 2'b00);
      nchk++;
      if (err !== 1'b1 || busy !== 1'b1 || en !== 2'b11) begin
         nfail++;
         $display("FAIL drop_step err=%b busy=%b en=%b want 1/1/11", err, busy, en);
      end
      tick();
      nchk++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL drop_pulse err=%b busy=%b want 0/1", err, busy);
      end
      issue(2'b00, 16'd0, 2'b00);
      nchk++;
      if (en !== 2'b00 || done !== 1'b0 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL halt_cmd en=%b done=%b busy=%b want 00/0/0", en, done, busy);
      end
      tick();
      nchk++;
      if (done !== 1'b0 || err !== 1'b0) begin
         nfail++;
         $display("FAIL halt_nodone done=%b err=%b want 0/0", done, err);
      end
      issue(2'b11, 16'd0, 2'b10);
      issue(2'b01, 16'd0, 2'b00);
      nchk++;
      if (en !== 2'b10 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL mask10_run en=%b busy=%b want 10/1", en, busy);
      end
      issue(2'b00, 16'd0, 2'b00);
   endtask

   task automatic test_zero();
      issue(2'b11, 16'd0, 2'b11);
      issue(2'b10, 16'd0, 2'b00);
      nchk++;
      if (done !== 1'b1 || en !== 2'b00 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL step0 done=%b en=%b busy=%b want 1/00/0", done, en, busy);
      end
      tick();
      nchk++;
      if (done !== 1'b0 || en !== 2'b00) begin
         nfail++;
         $display("FAIL step0_after done=%b en=%b want 0/00", done, en);
      end
      issue(2'b11, 16'd0, 2'b00);
      issue(2'b01, 16'd0, 2'b00);
      nchk++;
      if (done !== 1'b1 || en !== 2'b00 || err !== 1'b0) begin
         nfail++;
         $display("FAIL run_mask0 done=%b en=%b err=%b want 1/00/0", done, en, err);
      end
      tick();
      nchk++;
      if (en !== 2'b00 || u_if.cmd_ready_o_w !== 1'b1) begin
         nfail++;
         $display("FAIL run_mask0_after en=%b rdy=%b want 00/1", en, u_if.cmd_ready_o_w);
      end
   endtask

   task automatic test_halt_wins();
      issue(2'b11, 16'd0, 2'b11);
      issue(2'b10, 16'd2, 2'b00);
      tick();
      nchk++;
      if (en !== 2'b11 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL step2_last en=%b busy=%b want 11/1", en, busy);
      end
      issue(2'b00, 16'd0, 2'b00);
      nchk++;
      if (done !== 1'b0 || en !== 2'b00 || busy !== 1'b0) begin
         nfail++;
         $display("FAIL halt_wins done=%b en=%b busy=%b want 0/00/0", done, en, busy);
      end
   endtask

   task automatic test_reset_mid_step();
      int seen_done;
      seen_done = 0;
      issue(2'b10, 16'd100, 2'b00);
      repeat (49) tick();
      nchk++;
      if (en !== 2'b11 || busy !== 1'b1) begin
         nfail++;
         $display("FAIL step100_mid en=%b busy=%b want 11/1", en, busy);
      end
      rst_n = 1'b0;
      #1;
      nchk++;
      if (en !== 2'b00 || busy !== 1'b0 || u_if.cmd_ready_o_w !== 1'b0) begin
         nfail++;
         $display("FAIL rst_async en=%b busy=%b rdy=%b want 00/0/0",
                  en, busy, u_if.cmd_ready_o_w);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (done !== 1'b0) seen_done++;
         tick();
      end
      nchk++;
      if (seen_done != 0 || done !== 1'b0 || u_if.cmd_ready_o_w !== 1'b1) begin
         nfail++;
         $display("FAIL rst_nodone seen=%0d rdy=%b want 0/1",
                  seen_done, u_if.cmd_ready_o_w);
      end
   endtask

   initial begin
      halt_req           = 2'b00;
      u_if.cmd_valid_i_w = 1'b0;
      u_if.cmd_op_i_w    = 2'b00;
      u_if.cmd_cnt_i_w   = 16'd0;
      u_if.cmd_mask_i_w  = 2'b00;
      rst_n              = 1'b0;
      test_reset();
      test_step();
      test_run_halt_req();
      test_cmd_in_run();
      test_zero();
      test_halt_wins();
      test_reset_mid_step();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
